// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives the word-aligned
// fetch address to the combinational instruction memory, and registers the
// returned word into the IF/ID pipeline register. Handles stall, taken
// redirects from execute, and a terminal fault on misaligned redirect targets.
module fetch_stage #(
  parameter int unsigned                     DATA_WIDTH_LENGTH = 32,
  parameter int unsigned                     INST_WIDTH_LENGTH = 32,
  parameter logic [DATA_WIDTH_LENGTH-1:0]    RESET_PC          = 32'h0000_0000,
  parameter logic [INST_WIDTH_LENGTH-1:0]    NOP_INST          = 32'h0000_0013
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_stall,
  input  logic                         i_redirect,
  input  logic [DATA_WIDTH_LENGTH-1:0] i_redirect_pc,
  output logic [DATA_WIDTH_LENGTH-1:0] o_imem_addr,
  input  logic [INST_WIDTH_LENGTH-1:0] i_imem_data,
  output logic [DATA_WIDTH_LENGTH-1:0] o_pc,
  output logic [DATA_WIDTH_LENGTH-1:0] o_pc_plus4,
  output logic [INST_WIDTH_LENGTH-1:0] o_inst,
  output logic                         o_valid,
  output logic                         o_fault,
  output logic [DATA_WIDTH_LENGTH-1:0] o_fault_addr,
  output logic [31:0]                  o_fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                         state;
  logic [DATA_WIDTH_LENGTH-1:0]   pc;
  logic [DATA_WIDTH_LENGTH-1:0]   pc_next_seq;
  logic                           redirect_misaligned;

  // The PC register goes straight to memory; the low two bits never leave 00
  // because only aligned targets and +4 increments are ever loaded.
  assign o_imem_addr         = pc;
  assign pc_next_seq         = pc + DATA_WIDTH_LENGTH'(4);
  assign o_pc_plus4          = o_pc + DATA_WIDTH_LENGTH'(4);
  assign redirect_misaligned = (i_redirect_pc[1:0] != 2'b00);

  // Fetch FSM: one boot cycle, then redirect > stall > sequential fetch, with a terminal fault state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      o_pc          <= '0;
      o_inst        <= NOP_INST;
      o_valid       <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_addr  <= '0;
      o_fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (i_redirect) begin
            o_valid <= 1'b0;
            o_inst  <= NOP_INST;
            if (redirect_misaligned) begin
              state        <= FAULT;
              o_fault      <= 1'b1;
              o_fault_addr <= i_redirect_pc;
            end else begin
              pc <= i_redirect_pc;
            end
          end else if (!i_stall) begin
            o_pc          <= pc;
            o_inst        <= i_imem_data;
            o_valid       <= 1'b1;
            pc            <= pc_next_seq;
            o_fetch_count <= o_fetch_count + 32'd1;
          end
        end
        FAULT: begin
          o_valid <= 1'b0;
          o_fault <= 1'b1;
        end
        default: begin
          state   <= FAULT;
          o_valid <= 1'b0;
          o_fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue holds the fetch each
// driven cycle should produce; entries are popped when the IF/ID register
// shows a valid instruction. A second instance checks PC wraparound.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data;
  logic [31:0] pc, pc_plus4, inst, fault_addr, fetch_count;
  logic        valid, fault;

  logic        b_rst_n, b_stall, b_redirect;
  logic [31:0] b_redirect_pc, b_imem_addr, b_imem_data;
  logic [31:0] b_pc, b_pc_plus4, b_inst, b_fault_addr, b_fetch_count;
  logic        b_valid, b_fault;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  // Small instruction memory model with a few fixed words and an address-derived filler.
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: memword = 32'h0050_0093;
      32'h0000_0004: memword = 32'h00A0_0113;
      32'h0000_0008: memword = 32'h0020_81B3;
      32'h0000_0040: memword = 32'h0640_0213;
      default:       memword = {a[19:0], 12'h093};
    endcase
  endfunction

  assign imem_data   = memword(imem_addr);
  assign b_imem_data = memword(b_imem_addr);

  fetch_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_inst(inst), .o_valid(valid),
    .o_fault(fault), .o_fault_addr(fault_addr), .o_fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_stall(b_stall), .i_redirect(b_redirect),
    .i_redirect_pc(b_redirect_pc), .o_imem_addr(b_imem_addr), .i_imem_data(b_imem_data),
    .o_pc(b_pc), .o_pc_plus4(b_pc_plus4), .o_inst(b_inst), .o_valid(b_valid),
    .o_fault(b_fault), .o_fault_addr(b_fault_addr), .o_fetch_count(b_fetch_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushA(input logic [31:0] p, input logic [31:0] c);
    exp_t e;
    e.pc = p; e.inst = memword(p); e.cnt = c;
    sb_a.push_back(e);
  endtask

  task automatic pushB(input logic [31:0] p, input logic [31:0] c);
    exp_t e;
    e.pc = p; e.inst = memword(p); e.cnt = c;
    sb_b.push_back(e);
  endtask

  task automatic popCheckA(input string tag);
    exp_t e;
    checkOutput({tag, "_valid"}, {31'd0, valid}, 32'd1);
    if (sb_a.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_a.pop_front();
      checkOutput({tag, "_pc"}, pc, e.pc);
      checkOutput({tag, "_inst"}, inst, e.inst);
      checkOutput({tag, "_count"}, fetch_count, e.cnt);
      checkOutput({tag, "_plus4"}, pc_plus4, e.pc + 32'd4);
    end
  endtask

  task automatic popCheckB(input string tag);
    exp_t e;
    checkOutput({tag, "_valid"}, {31'd0, b_valid}, 32'd1);
    if (sb_b.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_b.pop_front();
      checkOutput({tag, "_pc"}, b_pc, e.pc);
      checkOutput({tag, "_inst"}, b_inst, e.inst);
      checkOutput({tag, "_count"}, b_fetch_count, e.cnt);
      checkOutput({tag, "_plus4"}, b_pc_plus4, e.pc + 32'd4);
    end
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_pc"}, pc, 32'd0);
    checkOutput({tag, "_plus4"}, pc_plus4, 32'd4);
    checkOutput({tag, "_inst"}, inst, NOP);
    checkOutput({tag, "_valid"}, {31'd0, valid}, 32'd0);
    checkOutput({tag, "_fault"}, {31'd0, fault}, 32'd0);
    checkOutput({tag, "_faddr"}, fault_addr, 32'd0);
    checkOutput({tag, "_count"}, fetch_count, 32'd0);
    checkOutput({tag, "_imem"}, imem_addr, 32'd0);
  endtask

  // Directed sequence: reset, fetch, stall, redirect, fault, async reset, wraparound.
  initial begin
    clk = 1'b0;
    rst_n = 1'b1; b_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    b_stall = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'd0;
    #1;
    rst_n = 1'b0; b_rst_n = 1'b0;
    tick(); tick();
    checkResetA("reset");

    @(negedge clk); rst_n = 1'b1;
    tick();
    checkOutput("boot_valid", {31'd0, valid}, 32'd0);
    checkOutput("boot_imem", imem_addr, 32'd0);

    pushA(32'h0, 32'd1); tick(); popCheckA("fetch0");
    pushA(32'h4, 32'd2); tick(); popCheckA("fetch4");

    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_pc", pc, 32'h4);
      checkOutput("stall_inst", inst, 32'h00A0_0113);
      checkOutput("stall_imem", imem_addr, 32'h8);
      checkOutput("stall_count", fetch_count, 32'd2);
      checkOutput("stall_valid", {31'd0, valid}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'd0);
    pushA(32'h8, 32'd3); tick(); popCheckA("fetch8");
    pushA(32'hC, 32'd4); tick(); popCheckA("fetchC");

    applyStimulus(1'b1, 1'b1, 32'h40);
    tick();
    checkOutput("redir_valid", {31'd0, valid}, 32'd0);
    checkOutput("redir_inst", inst, NOP);
    checkOutput("redir_imem", imem_addr, 32'h40);
    checkOutput("redir_count", fetch_count, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0);
    pushA(32'h40, 32'd5); tick(); popCheckA("fetch40");

    applyStimulus(1'b0, 1'b1, 32'h42);
    tick();
    checkOutput("fault_flag", {31'd0, fault}, 32'd1);
    checkOutput("fault_addr", fault_addr, 32'h42);
    checkOutput("fault_valid", {31'd0, valid}, 32'd0);
    checkOutput("fault_inst", inst, NOP);
    checkOutput("fault_imem", imem_addr, 32'h44);
    applyStimulus(1'b1, 1'b1, 32'h80); tick();
    applyStimulus(1'b0, 1'b1, 32'h100); tick();
    applyStimulus(1'b0, 1'b0, 32'd0); tick();
    checkOutput("fhold_flag", {31'd0, fault}, 32'd1);
    checkOutput("fhold_addr", fault_addr, 32'h42);
    checkOutput("fhold_valid", {31'd0, valid}, 32'd0);
    checkOutput("fhold_imem", imem_addr, 32'h44);
    checkOutput("fhold_count", fetch_count, 32'd5);

    @(negedge clk); rst_n = 1'b0;
    #1;
    checkResetA("fault_reset");
    @(negedge clk); rst_n = 1'b1;
    tick();
    pushA(32'h0, 32'd1); tick(); popCheckA("refetch0");
    pushA(32'h4, 32'd2); tick(); popCheckA("refetch4");

    applyStimulus(1'b0, 1'b1, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetA("async_reset");
    @(negedge clk); rst_n = 1'b1;
    tick();
    checkOutput("boot_ignore_imem", imem_addr, 32'd0);
    checkOutput("boot_ignore_valid", {31'd0, valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    pushA(32'h0, 32'd1); tick(); popCheckA("post_async0");

    checkOutput("wrap_reset_pc", b_pc, 32'd0);
    checkOutput("wrap_reset_imem", b_imem_addr, 32'hFFFF_FFF8);
    @(negedge clk); b_rst_n = 1'b1;
    tick();
    checkOutput("wrap_boot_valid", {31'd0, b_valid}, 32'd0);
    pushB(32'hFFFF_FFF8, 32'd1); tick(); popCheckB("wrap0");
    pushB(32'hFFFF_FFFC, 32'd2); tick(); popCheckB("wrap1");
    checkOutput("wrap_plus4_zero", b_pc_plus4, 32'd0);
    pushB(32'h0000_0000, 32'd3); tick(); popCheckB("wrap2");

    checkOutput("sb_a_drained", sb_a.size(), 32'd0);
    checkOutput("sb_b_drained", sb_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I datapath, directly upstream of the instruction memory. Holds the program counter, drives the word-aligned fetch address into the combinational instruction memory, captures the returned word into the IF/ID pipeline register, and handles stall, redirect (branch/jump) and misaligned-target fault. The decode stage consumes its outputs.

## Interface
- DATA_WIDTH_LENGTH, 32, PC/address width
- INST_WIDTH_LENGTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned)
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Clocking and reset: one clock; reset is asynchronous and active-low.

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold PC and IF/ID register
- i_redirect  in  1  taken branch/jump from execute
- i_redirect_pc  in  DATA_WIDTH_LENGTH  redirect target
- o_imem_addr  out  DATA_WIDTH_LENGTH  fetch address to instruction memory (= PC register)
- i_imem_data  in  INST_WIDTH_LENGTH  instruction word returned combinationally by memory
- o_pc  out  DATA_WIDTH_LENGTH  PC of instruction in IF/ID
- o_pc_plus4  out  DATA_WIDTH_LENGTH  o_pc + 4, modulo 2^32
- o_inst  out  INST_WIDTH_LENGTH  instruction in IF/ID
- o_valid  out  1  IF/ID holds a real instruction
- o_fault  out  1  misaligned redirect detected; fetch halted
- o_fault_addr  out  DATA_WIDTH_LENGTH  offending redirect target
- o_fetch_count  out  32  number of instructions captured valid, wraps

## Operation
- States: BOOT, RUN, FAULT.
- Reset (async, any time, including mid-stall or mid-redirect): pc = RESET_PC, state = BOOT, o_pc = 0, o_inst = NOP_INST, o_valid = 0, o_fault = 0, o_fault_addr = 0, o_fetch_count = 0. o_pc_plus4 therefore = 4.
- BOOT: one cycle; next edge → RUN, no capture, PC unchanged, i_stall/i_redirect ignored.
- RUN, per rising edge, priority order:
  - i_redirect=1, i_redirect_pc[1:0]≠0: state → FAULT, o_fault_addr = i_redirect_pc, PC unchanged, IF/ID flushed (o_valid=0, o_inst=NOP_INST).
  - i_redirect=1, aligned target: PC = i_redirect_pc, IF/ID flushed. Overrides i_stall.
  - i_stall=1: PC, IF/ID, counter all hold.
  - otherwise: IF/ID = {pc, i_imem_data}, o_valid=1, PC = PC+4 (modulo 2^32, wraps 32'hFFFF_FFFC → 0), o_fetch_count += 1 (modulo 2^32).
- FAULT: terminal until reset. o_fault=1, o_valid=0, PC and counter frozen, all inputs ignored.
- o_imem_addr always = PC register; bits [1:0] are always 00, so memory never returns high-impedance. Addresses above the memory's 20-bit window alias; the stage does no range check.
- o_pc_plus4 computed combinationally from o_pc.

## Timing
- Fetch latency: PC presented at o_imem_addr in cycle N; word captured at end of cycle N; visible on o_inst in cycle N+1.
- Throughput: one instruction per cycle without stall/redirect.
- Redirect asserted in cycle N: o_valid=0 in cycle N+1 (one bubble); target instruction on o_inst with o_valid=1 in cycle N+2.
- Redirect and stall in the same cycle: redirect wins.
- First valid instruction after reset release: BOOT cycle, then RESET_PC fetch → o_valid=1 two edges after i_rst_n rises.
- o_fault asserts the cycle after the misaligned redirect edge and holds until reset.
- All outputs registered except o_imem_addr (register direct) and o_pc_plus4 (adder from o_pc).

## Test plan
- Reset, memory words 0x00500093, 0x00A00113, 0x002081B3 at 0x0/0x4/0x8 → after BOOT, o_inst sequence matches, o_pc = 0,4,8, o_valid=1, o_fetch_count = 1,2,3.
- Stall for 3 cycles after second fetch → o_pc=4, o_inst=0x00A00113, o_imem_addr=8, count=2 held; resumes with o_pc=8.
- Redirect to 0x40 while stalled → next cycle o_valid=0, o_inst=0x00000013; following cycle o_pc=0x40, o_inst = word at 0x40.
- Redirect to 0x42 → o_fault=1, o_fault_addr=0x42, o_valid=0, PC frozen; further redirects/stalls ignored; i_rst_n low clears to reset values.
- RESET_PC=32'hFFFF_FFF8, run 3 cycles → o_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000; o_pc_plus4 at FFFF_FFFC = 0.
- Assert i_rst_n low mid-redirect (asynchronously, between edges) → outputs at reset values immediately, state BOOT.
